pll_lock_sequencer: RTL and testbench

Reset-and-lock controller for the system PLL (50 MHz reference, 48/24/0.96 MHz outputs). It runs in the reference clock domain and drives the PLL reset. It monitors the PLL lock output, which is asynchronous to this block. It releases a single `ready` qualifier to downstream logic only after lock has been stable for a programmed interval, and it retries the PLL reset on lock timeout or lock loss, up to a bounded retry count.

---
 rtl/pll_lock_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Reset-and-lock controller for the system PLL. Runs entirely in the
// reference clock domain. It pulses the PLL reset, waits for the PLL to
// report lock, and requires lock to be held for a programmed number of
// cycles before raising ready. A lock timeout or a lock loss while running
// restarts the reset sequence. After too many failed attempts it parks in
// FAULT until software asks for a relock or the block is reset.
//
// Ports:
//   refclk_i      reference clock, the only clock of this block
//   rst_ni        asynchronous active-low reset
//   pll_locked_i  raw PLL lock indication, asynchronous to refclk_i
//   relock_req_i  single-cycle request to restart the whole sequence
//   pll_rst_o     active-high PLL reset
//   ready_o       PLL clocks are valid; releases downstream reset
//   lock_lost_o   one-cycle pulse when lock drops while running
//   fault_o       retry budget exhausted
//   retry_cnt_o   failed attempts in the current sequence
//   state_o       encoded state (RESET_PLL=0 .. FAULT=4)
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 7
) (
   input  logic       refclk_i,
   input  logic       rst_ni,
   input  logic       pll_locked_i,
   input  logic       relock_req_i,
   output logic       pll_rst_o,
   output logic       ready_o,
   output logic       lock_lost_o,
   output logic       fault_o,
   output logic [3:0] retry_cnt_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_e;

   // One counter is shared by the pulse, timeout and stable phases because
   // only one of them is ever active; it is sized for the largest of them.
   localparam int MaxAB     = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                              RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int MaxCycles = (MaxAB > LOCK_STABLE_CYCLES) ? MaxAB : LOCK_STABLE_CYCLES;
   localparam int CW        = $clog2(MaxCycles) + 1;

   // Terminal values are "last count minus one" because the cycle on which
   // the counter would reach the limit is the cycle that leaves the state.
   localparam logic [CW-1:0] RstLast     = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TimeoutLast = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] StableLast  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [3:0]    RetryMax    = 4'(MAX_RETRIES);

   logic          lockSync1_q;
   logic          lockedS_q;
   state_e        state_q,  state_d;
   logic [CW-1:0] cnt_q,    cnt_d;
   logic [3:0]    retry_q,  retry_d;
   logic          lockLost_d;
   logic          pllRst_q;
   logic          ready_q;
   logic          lockLost_q;
   logic          fault_q;

   // Two-flop synchronizer for the raw lock input. Everything downstream
   // looks only at lockedS_q, never at the raw pin.
   always_ff @(posedge refclk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lockSync1_q <= 1'b0;
         lockedS_q   <= 1'b0;
      end else begin
         lockSync1_q <= pll_locked_i;
         lockedS_q   <= lockSync1_q;
      end
   end

   // Next-state logic. A relock request overrides whatever the current
   // state would otherwise do (timeout, lock loss) except while the PLL is
   // already being reset, where restarting the pulse would gain nothing.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      retry_d    = retry_q;
      lockLost_d = 1'b0;

      if (relock_req_i && (state_q != RESET_PLL)) begin
         state_d = RESET_PLL;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            RESET_PLL: begin
               if (cnt_q >= RstLast) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            WAIT_LOCK: begin
               if (lockedS_q) begin
                  // The first locked cycle already counts toward stability,
                  // so a one-cycle stability window goes straight to RUN.
                  if (LOCK_STABLE_CYCLES == 1) begin
                     state_d = RUN;
                     cnt_d   = '0;
                     retry_d = '0;
                  end else begin
                     state_d = STABLE;
                     cnt_d   = CW'(1);
                  end
               end else if (cnt_q >= TimeoutLast) begin
                  cnt_d = '0;
                  if (retry_q >= RetryMax) begin
                     state_d = FAULT;
                  end else begin
                     retry_d = retry_q + 4'd1;
                     state_d = RESET_PLL;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            STABLE: begin
               if (!lockedS_q) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q >= StableLast) begin
                  state_d = RUN;
                  cnt_d   = '0;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            RUN: begin
               if (!lockedS_q) begin
                  state_d    = RESET_PLL;
                  cnt_d      = '0;
                  lockLost_d = 1'b1;
               end
            end

            FAULT: begin
               state_d = FAULT;
            end

            default: begin
               state_d = RESET_PLL;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and output registers. Outputs are decoded from the next state so
   // they change on the same edge as the state they describe.
   always_ff @(posedge refclk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= RESET_PLL;
         cnt_q      <= '0;
         retry_q    <= '0;
         pllRst_q   <= 1'b1;
         ready_q    <= 1'b0;
         lockLost_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         pllRst_q   <= (state_d == RESET_PLL) || (state_d == FAULT);
         ready_q    <= (state_d == RUN);
         lockLost_q <= lockLost_d;
         fault_q    <= (state_d == FAULT);
      end
   end

   assign pll_rst_o   = pllRst_q;
   assign ready_o     = ready_q;
   assign lock_lost_o = lockLost_q;
   assign fault_o     = fault_q;
   assign retry_cnt_o = retry_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Drives pll_lock_sequencer (RST_PULSE=4, TIMEOUT=32, STABLE=8, RETRIES=2)
// from a table of segments. Each segment holds the inputs for n cycles and
// states the outputs expected after every one of those cycles; a segment
// may start with an asynchronous reset, whose effect is checked before any
// clock edge arrives.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

   logic       refclk    = 1'b0;
   logic       rst_n     = 1'b1;
   logic       pllLocked = 1'b0;
   logic       relockReq = 1'b0;
   logic       pllRst;
   logic       ready;
   logic       lockLost;
   logic       fault;
   logic [3:0] retryCnt;
   logic [2:0] state;

   pll_lock_sequencer #(
      .RST_PULSE_CYCLES   (4),
      .LOCK_TIMEOUT_CYCLES(32),
      .LOCK_STABLE_CYCLES (8),
      .MAX_RETRIES        (2)
   ) dut (
      .refclk_i    (refclk),
      .rst_ni      (rst_n),
      .pll_locked_i(pllLocked),
      .relock_req_i(relockReq),
      .pll_rst_o   (pllRst),
      .ready_o     (ready),
      .lock_lost_o (lockLost),
      .fault_o     (fault),
      .retry_cnt_o (retryCnt),
      .state_o     (state)
   );

   // 10-unit reference clock
   always #5 refclk = ~refclk;

   typedef struct packed {
      logic       pllRst;
      logic       ready;
      logic       lockLost;
      logic       fault;
      logic [3:0] retry;
      logic [2:0] state;
   } out_t;

   typedef struct packed {
      int   n;
      logic rstBefore;
      logic locked;
      logic relock;
      out_t exp;
   } vec_t;

   vec_t  vecs[$];
   out_t  expQ[$];
   string nameQ[$];
   int    compared   = 0;
   int    mismatched = 0;

   // Append one segment to the stimulus table
   task automatic addSeg(input int n, input logic rb, input logic lk, input logic rl,
                         input logic pr, input logic rd, input logic ll, input logic ft,
                         input logic [3:0] rt, input logic [2:0] st);
      vec_t v;
      v.n            = n;
      v.rstBefore    = rb;
      v.locked       = lk;
      v.relock       = rl;
      v.exp.pllRst   = pr;
      v.exp.ready    = rd;
      v.exp.lockLost = ll;
      v.exp.fault    = ft;
      v.exp.retry    = rt;
      v.exp.state    = st;
      vecs.push_back(v);
   endtask

   function automatic string fmt(input out_t o);
      return $sformatf("pll_rst=%0b ready=%0b lock_lost=%0b fault=%0b retry=%0d state=%0d",
                       o.pllRst, o.ready, o.lockLost, o.fault, o.retry, o.state);
   endfunction

   // Pop the oldest expectation and compare it with what the DUT shows now
   task automatic checkOutput();
      out_t  exp;
      out_t  act;
      string nm;
      act.pllRst   = pllRst;
      act.ready    = ready;
      act.lockLost = lockLost;
      act.fault    = fault;
      act.retry    = retryCnt;
      act.state    = state;
      compared++;
      if (expQ.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard-empty: got %s, expected an entry", fmt(act));
      end else begin
         exp = expQ.pop_front();
         nm  = nameQ.pop_front();
         if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %s, expected %s", nm, fmt(act), fmt(exp));
         end
      end
   endtask

   // Assert reset away from any clock edge and check the outputs settle
   // before the next edge, then release it just after an edge.
   task automatic doReset(input int idx);
      out_t r;
      r.pllRst   = 1'b1;
      r.ready    = 1'b0;
      r.lockLost = 1'b0;
      r.fault    = 1'b0;
      r.retry    = 4'd0;
      r.state    = 3'd0;
      rst_n      = 1'b0;
      pllLocked  = 1'b0;
      relockReq  = 1'b0;
      #1;
      expQ.push_back(r);
      nameQ.push_back($sformatf("asyncReset.seg%0d", idx));
      checkOutput();
      @(posedge refclk);
      #1;
      rst_n = 1'b1;
   endtask

   // Play one segment: inputs held for n edges, outputs checked after each
   task automatic applyStimulus(input vec_t v, input int idx);
      if (v.rstBefore) doReset(idx);
      pllLocked = v.locked;
      relockReq = v.relock;
      for (int c = 0; c < v.n; c++) begin
         expQ.push_back(v.exp);
         nameQ.push_back($sformatf("seg%0d.cyc%0d", idx, c));
         @(posedge refclk);
         #1;
         checkOutput();
      end
   endtask

   initial begin
      // n  rst lk rl | rst rdy ll flt retry st
      // Nominal lock: lock first sampled 10 edges after pll_rst falls
      addSeg( 3, 1, 0, 0,  1, 0, 0, 0, 0, 0);
      addSeg(10, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      addSeg( 2, 0, 1, 0,  0, 0, 0, 0, 0, 1);
      addSeg( 7, 0, 1, 0,  0, 0, 0, 0, 0, 2);
      addSeg( 3, 0, 1, 0,  0, 1, 0, 0, 0, 3);
      // Unstable lock: high 5, low 2, then held high
      addSeg( 3, 1, 0, 0,  1, 0, 0, 0, 0, 0);
      addSeg( 1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      addSeg( 2, 0, 1, 0,  0, 0, 0, 0, 0, 1);
      addSeg( 3, 0, 1, 0,  0, 0, 0, 0, 0, 2);
      addSeg( 2, 0, 0, 0,  0, 0, 0, 0, 0, 2);
      addSeg( 2, 0, 1, 0,  0, 0, 0, 0, 0, 1);
      addSeg( 7, 0, 1, 0,  0, 0, 0, 0, 0, 2);
      addSeg( 2, 0, 1, 0,  0, 1, 0, 0, 0, 3);
      // Timeout to fault: three 4-cycle pulses, 32-cycle gaps
      addSeg( 3, 1, 0, 0,  1, 0, 0, 0, 0, 0);
      addSeg(32, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      addSeg( 4, 0, 0, 0,  1, 0, 0, 0, 1, 0);
      addSeg(32, 0, 0, 0,  0, 0, 0, 0, 1, 1);
      addSeg( 4, 0, 0, 0,  1, 0, 0, 0, 2, 0);
      addSeg(32, 0, 0, 0,  0, 0, 0, 0, 2, 1);
      addSeg( 5, 0, 0, 0,  1, 0, 0, 1, 2, 4);
      // Fault recovery via relock with lock present
      addSeg( 2, 0, 1, 0,  1, 0, 0, 1, 2, 4);
      addSeg( 1, 0, 1, 1,  1, 0, 0, 0, 0, 0);
      addSeg( 3, 0, 1, 0,  1, 0, 0, 0, 0, 0);
      addSeg( 1, 0, 1, 0,  0, 0, 0, 0, 0, 1);
      addSeg( 7, 0, 1, 0,  0, 0, 0, 0, 0, 2);
      addSeg( 2, 0, 1, 0,  0, 1, 0, 0, 0, 3);
      // One-cycle lock drop in RUN
      addSeg( 1, 0, 0, 0,  0, 1, 0, 0, 0, 3);
      addSeg( 1, 0, 1, 0,  0, 1, 0, 0, 0, 3);
      addSeg( 1, 0, 1, 0,  1, 0, 1, 0, 0, 0);
      addSeg( 3, 0, 1, 0,  1, 0, 0, 0, 0, 0);
      addSeg( 1, 0, 1, 0,  0, 0, 0, 0, 0, 1);
      addSeg( 7, 0, 1, 0,  0, 0, 0, 0, 0, 2);
      addSeg( 2, 0, 1, 0,  0, 1, 0, 0, 0, 3);
      // Relock coincident with lock loss; second relock in RESET_PLL ignored
      addSeg( 1, 0, 0, 0,  0, 1, 0, 0, 0, 3);
      addSeg( 1, 0, 1, 0,  0, 1, 0, 0, 0, 3);
      addSeg( 1, 0, 1, 1,  1, 0, 0, 0, 0, 0);
      addSeg( 1, 0, 1, 1,  1, 0, 0, 0, 0, 0);
      addSeg( 2, 0, 1, 0,  1, 0, 0, 0, 0, 0);
      addSeg( 1, 0, 1, 0,  0, 0, 0, 0, 0, 1);
      addSeg( 7, 0, 1, 0,  0, 0, 0, 0, 0, 2);
      addSeg( 1, 0, 1, 0,  0, 1, 0, 0, 0, 3);
      // Reach STABLE, then async reset mid-STABLE
      addSeg( 3, 1, 0, 0,  1, 0, 0, 0, 0, 0);
      addSeg( 1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      addSeg( 2, 0, 1, 0,  0, 0, 0, 0, 0, 1);
      addSeg( 3, 0, 1, 0,  0, 0, 0, 0, 0, 2);
      // Lock held through reset pulse, reach RUN, then async reset in RUN
      addSeg( 3, 1, 1, 0,  1, 0, 0, 0, 0, 0);
      addSeg( 1, 0, 1, 0,  0, 0, 0, 0, 0, 1);
      addSeg( 7, 0, 1, 0,  0, 0, 0, 0, 0, 2);
      addSeg( 2, 0, 1, 0,  0, 1, 0, 0, 0, 3);
      addSeg( 2, 1, 1, 0,  1, 0, 0, 0, 0, 0);

      #2;
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], i);
      end
      if (expQ.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL scoreboard-leftover: got %0d pending entries, expected 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Safety net in case the stimulus ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation time limit, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
